// File: rtl/tff_seq_pkg.sv
// ---------------------------------------------------------------------------
// tff_seq_pkg
// Shared types and constants for the T-flip-flop count sequencer.
//   state_t  : controller FSM state, 2-bit encoding
//   DIR_DOWN : dir value selecting a count from load_val down to 0
//   DIR_UP   : dir value selecting a count from 0 up to load_val
// ---------------------------------------------------------------------------
package tff_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// tff_cell
// One T flip-flop: a D flip-flop whose next value is q XOR t.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-high clear (q -> 0)
//   t     in   toggle enable for this edge
//   q     out  stored bit
//   qbar  out  complement of q
// ---------------------------------------------------------------------------
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q,
   output logic qbar
);

   logic q_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg <= 1'b0;
      end else begin
         q_reg <= q_reg ^ t;
      end
   end

   assign q    = q_reg;
   assign qbar = ~q_reg;

endmodule

// File: rtl/tff_count_sequencer.sv
// ---------------------------------------------------------------------------
// tff_count_sequencer
// Sequences a bank of WIDTH T flip-flops as a loadable up/down counter. The
// bank only ever changes through the toggle vector produced here, one per
// cycle. A start/done handshake frames each operation; pause freezes the
// count while running and abort drops back to IDLE without a done pulse.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset, also clears every cell
//   start    in   request, sampled only in IDLE
//   dir      in   1 = count up 0 -> load_val, 0 = count down load_val -> 0
//   load_val in   target (up) or initial value (down), captured with start
//   pause    in   hold the count for this RUN cycle
//   abort    in   leave LOAD/RUN for IDLE at the next edge, count holds
//   busy     out  high in LOAD and RUN
//   done     out  single-cycle pulse in DONE
//   count    out  q vector of the T-FF bank
// ---------------------------------------------------------------------------
module tff_count_sequencer
   import tff_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] load_val,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] count
);

   state_t           state_reg;
   logic             dir_reg;
   logic [WIDTH-1:0] val_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [WIDTH-1:0] q_vec;
   logic [WIDTH-1:0] qbar_vec;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] init_val;
   logic [WIDTH-1:0] target_val;
   logic [WIDTH-1:0] step_up;
   logic [WIDTH-1:0] step_dn;
   logic             at_target;

   assign init_val   = (dir_reg == DIR_UP) ? '0 : val_reg;
   assign target_val = (dir_reg == DIR_UP) ? val_reg : '0;
   assign at_target  = (q_vec == target_val);

   // Ripple toggle terms: a bit flips when every lower bit is 1 (increment)
   // or every lower bit is 0 (decrement). The down term uses the cells'
   // qbar outputs directly.
   assign step_up[0] = 1'b1;
   assign step_dn[0] = 1'b1;

   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_step
         assign step_up[gi] = &q_vec[gi-1:0];
         assign step_dn[gi] = &qbar_vec[gi-1:0];
      end
   endgenerate

   // Toggle vector. Abort beats everything; in RUN the target check
   // beats pause so a paused run that already sits on target still ends.
   always_comb begin
      t_vec = '0;
      case (state_reg)
         LOAD: begin
            if (!abort) begin
               t_vec = q_vec ^ init_val;
            end
         end
         RUN: begin
            if (!abort && !at_target && !pause) begin
               t_vec = (dir_reg == DIR_UP) ? step_up : step_dn;
            end
         end
         default: t_vec = '0;
      endcase
   end

   // Controller FSM with registered busy/done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         dir_reg   <= 1'b0;
         val_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  dir_reg   <= dir;
                  val_reg   <= load_val;
                  state_reg <= LOAD;
                  busy_reg  <= 1'b1;
               end else begin
                  busy_reg  <= 1'b0;
               end
            end
            LOAD: begin
               if (abort) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  state_reg <= RUN;
                  busy_reg  <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (at_target) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t_vec[gi]),
            .q     (q_vec[gi]),
            .qbar  (qbar_vec[gi])
         );
      end
   endgenerate

   assign busy  = busy_reg;
   assign done  = done_reg;
   assign count = q_vec;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tff_count_sequencer
// Stimulus issues operations and pushes the expected end-of-operation event
// (done pulse or busy falling without done) into a queue, computed from a
// plain integer model of the count. A separate monitor pops and compares
// whenever the DUT ends an operation.
// ---------------------------------------------------------------------------
module tb_tff_count_sequencer;
   import tff_seq_pkg::*;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             dir;
   logic [WIDTH-1:0] load_val;
   logic             pause;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] count;

   tff_count_sequencer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .dir      (dir),
      .load_val (load_val),
      .pause    (pause),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .count    (count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_done;
      int cnt;
      int at;
      int op;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cur_cnt = 0;
   int   op_id = 0;
   bit   prev_busy = 1'b0;

   function automatic void push_exp(input bit dn, input int c, input int at);
      exp_t e;
      e.is_done = dn;
      e.cnt     = c;
      e.at      = at;
      e.op      = op_id;
      exp_q.push_back(e);
   endfunction

   // Monitor: an operation ends either with a done pulse or with busy
   // falling while done stays low (abort or reset).
   initial begin
      exp_t e;
      bit   ev;
      forever begin
         @(negedge clk);
         if (busy === 1'b1 && done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL busy_done_overlap cyc=%0d: got busy=1 done=1, required not both high", cyc);
         end
         ev = (done === 1'b1) || (prev_busy && busy === 1'b0);
         if (ev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event cyc=%0d: got done=%0b count=%0d, required no event", cyc, done, count);
            end else begin
               e = exp_q.pop_front();
               if (e.is_done != done || e.cnt != int'(count) || e.at != cyc) begin
                  errors++;
                  $display("FAIL op%0d_end: got done=%0b count=%0d cyc=%0d, required done=%0b count=%0d cyc=%0d",
                           e.op, done, count, cyc, e.is_done, e.cnt, e.at);
               end else begin
                  $display("op %0d ended: done=%0b count=%0d cyc=%0d", e.op, done, count, cyc);
               end
            end
         end
         prev_busy = (busy === 1'b1);
      end
   end

   // One operation. Negative p_at/ab_at/rs_at disable that feature; the
   // step index k is 0 for the LOAD cycle and counts RUN cycles from 1.
   task automatic run_op(input bit d, input int val, input int p_at, input int p_len,
                         input int ab_at, input int rs_at, input bit stray);
      int init;
      int target;
      bit fin;
      bit ended_done;
      op_id++;
      init       = (d == DIR_UP) ? 0 : val;
      target     = (d == DIR_UP) ? val : 0;
      fin        = 1'b0;
      ended_done = 1'b0;
      start    = 1'b1;
      dir      = d;
      load_val = WIDTH'(val);
      @(posedge clk); #1;
      // Scramble the request inputs after capture.
      dir      = 1'($urandom);
      load_val = WIDTH'($urandom);
      for (int k = 0; k < 1000 && !fin; k++) begin
         start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
         pause = 1'b0;
         abort = 1'b0;
         if (k == rs_at) begin
            reset = 1'b1;
            push_exp(1'b0, 0, cyc + 1);
            cur_cnt = 0;
            fin = 1'b1;
         end else if (k == ab_at) begin
            abort = 1'b1;
            push_exp(1'b0, cur_cnt, cyc + 1);
            fin = 1'b1;
         end else if (k == 0) begin
            pause   = 1'($urandom_range(0, 1));
            cur_cnt = init;
         end else if (cur_cnt == target) begin
            pause = 1'($urandom_range(0, 1));
            push_exp(1'b1, cur_cnt, cyc + 1);
            fin = 1'b1;
            ended_done = 1'b1;
         end else if (k >= p_at && k < p_at + p_len) begin
            pause = 1'b1;
         end else begin
            cur_cnt = (d == DIR_UP) ? cur_cnt + 1 : cur_cnt - 1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      pause = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL op%0d_timeout: got no end within 1000 cycles, required end at count=%0d", op_id, target);
      end
      if (ended_done) begin
         // DONE cycle: start and abort must both be ignored here.
         start = stray;
         abort = stray;
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      dir      = 1'b0;
      load_val = '0;
      pause    = 1'b0;
      abort    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got count=%0d busy=%0b done=%0b, required 0 0 0", count, busy, done);
      end
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed cases.
      run_op(DIR_UP,   5,   -1, 0, -1, -1, 1'b0);
      run_op(DIR_DOWN, 3,   -1, 0, -1, -1, 1'b0);
      run_op(DIR_UP,   255, -1, 0, -1, -1, 1'b0);
      run_op(DIR_UP,   0,   -1, 0, -1, -1, 1'b0);
      run_op(DIR_DOWN, 0,   -1, 0, -1, -1, 1'b0);
      run_op(DIR_UP,   6,   3,  3, -1, -1, 1'b1);
      run_op(DIR_UP,   9,   -1, 0, 5,  -1, 1'b0);   // abort with count=4
      run_op(DIR_DOWN, 7,   -1, 0, 0,  -1, 1'b0);   // abort during LOAD
      run_op(DIR_UP,   9,   -1, 0, -1, 3,  1'b0);   // reset with count=2
      checks++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL after_mid_reset: got count=%0d busy=%0b done=%0b, required 0 0 0", count, busy, done);
      end

      // Randomized operations.
      for (int n = 0; n < 30; n++) begin
         bit d;
         int val;
         int ab;
         int rs;
         d   = 1'($urandom_range(0, 1));
         val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
         ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, val + 1)) : -1;
         rs  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, val + 1)) : -1;
         run_op(d, val, int'($urandom_range(1, 10)), int'($urandom_range(0, 4)), ab, rs,
                1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected: got %0d pending events, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
